load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Data-memory access stage directly downstream of the multicycle control FSM.
- Accepts one load/store command per handshake and drives a doubleword-wide, ack-based data memory with byte strobes.
- Returns load data already sliced and sign/zero-extended per funct3, ready for register write-back.
- Replaces the fixed one-cycle wait state with a real handshake plus a timeout counter.

Parameters:
- DATA_W, 64, data path width in bits; fixed at 64, so the lane count is DATA_W/8 = 8.
- ADDR_W, 64, byte address width.
- TIMEOUT, 255, maximum cycles to wait for mem_ack before aborting with an error; 8-bit counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  command valid from the control FSM.
- req_ready  out  1  high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV64 load/store funct3.
- req_addr  in  ADDR_W  byte address (ALUOut).
- req_wdata  in  DATA_W  store data (regB), least-significant-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_W  extended load data; 0 for stores.
- resp_err  out  1  qualifies resp_valid: timeout, misaligned or illegal funct3.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  doubleword-aligned address, bits [2:0] = 0.
- mem_wdata  out  DATA_W  store data shifted to its byte lane.
- mem_wstrb  out  8  byte-enable strobes.
- mem_ack  in  1  memory completion; read data valid in the same cycle.
- mem_rdata  in  DATA_W  read doubleword.

Behaviour:
- Reset (reset=0, asynchronous): FSM goes to IDLE. Every output is 0 except req_ready=1. The timeout counter clears. Any in-flight memory transaction is abandoned.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - req_valid=1 (and therefore req_ready=1) latches the command.
  - Size from funct3[1:0]: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes, 3 = 8 bytes.
  - Legal loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU. Legal stores: 000 SB, 001 SH, 010 SW, 011 SD.
  - Illegal funct3 (load 111, store 1xx) or misaligned address (addr mod size != 0): go to RESP with resp_err=1. No memory access is made.
  - Otherwise go to ISSUE.
- ISSUE:
  - mem_req=1; mem_addr = addr with bits [2:0] cleared.
  - Stores: mem_we=1; mem_wstrb has `size` ones shifted left by addr[2:0]; mem_wdata = req_wdata shifted left by 8*addr[2:0]. Loads: mem_we=0, mem_wstrb=0.
  - Mem outputs stay stable until mem_ack.
  - On mem_ack, loads capture mem_rdata shifted right by 8*addr[2:0], truncated to size, then extended: sign-extend for LB/LH/LW, zero-extend for LBU/LHU/LWU/LD. Go to RESP.
  - The counter increments every cycle in ISSUE without ack. When it reaches TIMEOUT, drop mem_req and go to RESP with resp_err=1 and resp_rdata=0.
- RESP: resp_valid=1 for exactly one cycle, then return to IDLE. resp_rdata and resp_err are registered and valid only with resp_valid.
- Latency: accept at cycle 0; mem_req first high at cycle 1. An ack at cycle 1+k gives resp_valid at cycle 2+k. Minimum is 2 cycles. Error paths give resp_valid at cycle 1.
- Boundaries:
  - req_valid outside IDLE is ignored and never queued.
  - mem_ack outside ISSUE is ignored.
  - mem_ack in the same cycle the counter reaches TIMEOUT counts as a success.
  - A new request can be accepted in the cycle right after RESP.
  - Reset asserted in any state gives the reset values immediately.

Optional Feature:
- Macro: LSU_MISALIGN_SPLIT_EN.
- Defined:
  - Misaligned legal accesses do not error.
  - Accesses within one doubleword are issued as a single beat.
  - Accesses crossing a doubleword boundary are issued as two sequential beats (addr, then addr+8) with split strobes and data.
  - Loads merge the two beats before extension.
  - A timeout on either beat aborts with resp_err; a store whose first beat was acked is not rolled back.
- Undefined: misaligned accesses return resp_err with no memory access, as described above.

Test Plan:
- LD at 0x100, mem_rdata=0x1122334455667788, ack on first cycle: mem_addr=0x100, resp_valid at cycle 2, resp_rdata=0x1122334455667788, resp_err=0.
- LB at 0x103, mem_rdata=0x0000_0000_8000_0000: resp_rdata=0xFFFF_FFFF_FFFF_FF80. LBU at the same address returns 0x80.
- SH at 0x106, req_wdata=0xBEEF: mem_wstrb=0xC0, mem_wdata[63:48]=0xBEEF, mem_we=1; mem_req holds through a 5-cycle ack delay.
- LW at 0x102 without the macro: resp_err=1 at cycle 1, mem_req never asserted. With the macro: two beats at 0xF8-relative doubleword boundaries tested at 0x106 and the merged word returned.
- Load with mem_ack never asserted, TIMEOUT=255: mem_req drops after 255 cycles, resp_valid=1 with resp_err=1, and req_ready=1 on the next cycle.
- reset=0 in the middle of ISSUE: mem_req=0 asynchronously, no resp_valid, and a new LD after release completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: one command per handshake, ack-based 64-bit data memory.
// Define LSU_MISALIGN_SPLIT_EN to issue doubleword-crossing accesses as two beats.
module load_store_unit #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wstrb,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

    state_t state_q, state_d;

    logic              write_q, write_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [2:0]        off_q, off_d;
    logic              split_q, split_d;
    logic              beat_q, beat_d;
    logic [DATA_W-1:0] whi_q, whi_d;
    logic [7:0]        shi_q, shi_d;
    logic [DATA_W-1:0] rlo_q, rlo_d;
    logic [7:0]        cnt_q, cnt_d;

    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]        mem_wstrb_q, mem_wstrb_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;

    logic [3:0]          size_b;
    logic                illegal;
    logic                req_err;
    logic                crosses;
    logic [15:0]         strb16;
    logic [2*DATA_W-1:0] wdata128;
    logic [DATA_W-1:0]   rsh;
    logic [DATA_W-1:0]   ld_ext;

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;

    // Lane placement is computed 16 bytes wide; the upper half feeds a second beat.
    always_comb begin
        size_b   = 4'd1 << req_funct3[1:0];
        illegal  = req_write ? req_funct3[2] : (req_funct3 == 3'b111);
        strb16   = (16'd1 << size_b) - 16'd1;
        strb16   = strb16 << req_addr[2:0];
        wdata128 = {{DATA_W{1'b0}}, req_wdata} << {req_addr[2:0], 3'b000};
`ifdef LSU_MISALIGN_SPLIT_EN
        crosses  = |strb16[15:8];
        req_err  = illegal;
`else
        crosses  = 1'b0;
        case (req_funct3[1:0])
            2'd0:    req_err = illegal;
            2'd1:    req_err = illegal | req_addr[0];
            2'd2:    req_err = illegal | (|req_addr[1:0]);
            default: req_err = illegal | (|req_addr[2:0]);
        endcase
`endif
    end

    always_comb begin
        rsh = DATA_W'((beat_q ? {mem_rdata, rlo_q}
                              : {{DATA_W{1'b0}}, mem_rdata})
                      >> {off_q, 3'b000});
        case (funct3_q)
            3'b000:  ld_ext = {{(DATA_W-8){rsh[7]}}, rsh[7:0]};
            3'b001:  ld_ext = {{(DATA_W-16){rsh[15]}}, rsh[15:0]};
            3'b010:  ld_ext = {{(DATA_W-32){rsh[31]}}, rsh[31:0]};
            3'b100:  ld_ext = {{(DATA_W-8){1'b0}}, rsh[7:0]};
            3'b101:  ld_ext = {{(DATA_W-16){1'b0}}, rsh[15:0]};
            3'b110:  ld_ext = {{(DATA_W-32){1'b0}}, rsh[31:0]};
            default: ld_ext = rsh;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        split_d      = split_q;
        beat_d       = beat_q;
        whi_d        = whi_q;
        shi_d        = shi_q;
        rlo_d        = rlo_q;
        cnt_d        = cnt_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wstrb_d  = mem_wstrb_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        resp_err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    funct3_d = req_funct3;
                    off_d    = req_addr[2:0];
                    split_d  = crosses;
                    beat_d   = 1'b0;
                    cnt_d    = '0;
                    whi_d    = req_write ? wdata128[2*DATA_W-1:DATA_W] : '0;
                    shi_d    = req_write ? strb16[15:8] : '0;
                    if (req_err) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d     = ISSUE;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_write;
                        mem_addr_d  = {req_addr[ADDR_W-1:3], 3'b000};
                        mem_wdata_d = req_write ? wdata128[DATA_W-1:0] : '0;
                        mem_wstrb_d = req_write ? strb16[7:0] : '0;
                    end
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    cnt_d = '0;
                    if (split_q && !beat_q) begin
                        beat_d      = 1'b1;
                        rlo_d       = mem_rdata;
                        mem_addr_d  = mem_addr_q + ADDR_W'(8);
                        mem_wdata_d = whi_q;
                        mem_wstrb_d = shi_q;
                    end else begin
                        state_d      = RESP;
                        mem_req_d    = 1'b0;
                        mem_we_d     = 1'b0;
                        mem_addr_d   = '0;
                        mem_wdata_d  = '0;
                        mem_wstrb_d  = '0;
                        resp_valid_d = 1'b1;
                        resp_rdata_d = write_q ? '0 : ld_ext;
                    end
                end else if (cnt_q + 8'd1 == TO_LIM) begin
                    // Abandon the access; a first store beat already acked stays written.
                    state_d      = RESP;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    mem_addr_d   = '0;
                    mem_wdata_d  = '0;
                    mem_wstrb_d  = '0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            funct3_q     <= '0;
            off_q        <= '0;
            split_q      <= 1'b0;
            beat_q       <= 1'b0;
            whi_q        <= '0;
            shi_q        <= '0;
            rlo_q        <= '0;
            cnt_q        <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wstrb_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            split_q      <= split_d;
            beat_q       <= beat_d;
            whi_q        <= whi_d;
            shi_q        <= shi_d;
            rlo_q        <= rlo_d;
            cnt_q        <= cnt_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wstrb_q  <= mem_wstrb_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table plus timeout,
// reset, ignored-handshake and (with LSU_MISALIGN_SPLIT_EN) split sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_ack;
    logic [63:0] mem_rdata;

    localparam logic [63:0] JUNK = 64'hA5A5_5A5A_DEAD_BEEF;

    load_store_unit #(
        .DATA_W(64),
        .ADDR_W(64),
        .TIMEOUT(255)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_funct3(req_funct3),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          dly;
        logic        err;
        logic [63:0] maddr;
        logic [7:0]  strb;
        logic [63:0] mwdata;
        logic [63:0] exp_rd;
    } vec_t;

    int n_chk = 0;
    int n_err = 0;
    int vidx  = 0;
    vec_t vecs[$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL [%0d] %s: got %h expected %h", vidx, nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic wr, input logic [2:0] f3, input logic [63:0] addr,
        input logic [63:0] wdata, input logic [63:0] rdata, input int dly,
        input logic err, input logic [63:0] maddr, input logic [7:0] strb,
        input logic [63:0] mwdata, input logic [63:0] exp_rd);
        vec_t v;
        v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.dly = dly; v.err = err; v.maddr = maddr;
        v.strb = strb; v.mwdata = mwdata; v.exp_rd = exp_rd;
        return v;
    endfunction

    // Starts and ends #1 after a rising edge, with the DUT idle.
    task automatic run_txn(input vec_t v);
        req_valid  = 1'b1;
        req_write  = v.wr;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(negedge clk);
        chk("accept.ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (v.err) begin
            @(negedge clk);
            chk("err.resp_valid", resp_valid, 1);
            chk("err.resp_err", resp_err, 1);
            chk("err.rdata", resp_rdata, 0);
            chk("err.mem_req", mem_req, 0);
        end else begin
            for (int k = 0; k <= v.dly; k++) begin
                if (k == v.dly) begin
                    mem_ack   = 1'b1;
                    mem_rdata = v.rdata;
                end
                @(negedge clk);
                chk("iss.mem_req", mem_req, 1);
                chk("iss.mem_addr", mem_addr, v.maddr);
                chk("iss.mem_we", mem_we, v.wr);
                chk("iss.mem_wstrb", mem_wstrb, v.strb);
                chk("iss.mem_wdata", mem_wdata, v.mwdata);
                chk("iss.resp_valid", resp_valid, 0);
                @(posedge clk); #1;
                mem_ack   = 1'b0;
                mem_rdata = JUNK;
            end
            @(negedge clk);
            chk("ok.resp_valid", resp_valid, 1);
            chk("ok.resp_err", resp_err, 0);
            chk("ok.rdata", resp_rdata, v.exp_rd);
            chk("ok.mem_req", mem_req, 0);
            chk("ok.ready", req_ready, 0);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        mem_ack    = 1'b0;
        mem_rdata  = JUNK;

        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready", req_ready, 1);
        chk("rst.mem_req", mem_req, 0);
        chk("rst.mem_addr", mem_addr, 0);
        chk("rst.mem_wstrb", mem_wstrb, 0);
        chk("rst.resp_valid", resp_valid, 0);
        chk("rst.resp_err", resp_err, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        vecs.push_back(mk(0, 3'b011, 64'h100, 0, 64'h1122334455667788, 0,
                          0, 64'h100, 8'h00, 0, 64'h1122334455667788));
        vecs.push_back(mk(0, 3'b000, 64'h103, 0, 64'h80000000, 0,
                          0, 64'h100, 8'h00, 0, 64'hFFFFFFFFFFFFFF80));
        vecs.push_back(mk(0, 3'b100, 64'h103, 0, 64'h80000000, 0,
                          0, 64'h100, 8'h00, 0, 64'h80));
        vecs.push_back(mk(1, 3'b001, 64'h106, 64'hBEEF, 64'h1234, 5,
                          0, 64'h100, 8'hC0, 64'hBEEF000000000000, 0));
        vecs.push_back(mk(1, 3'b001, 64'h100, 64'h111122223333BEEF, 0, 0,
                          0, 64'h100, 8'h03, 64'h111122223333BEEF, 0));
        vecs.push_back(mk(0, 3'b001, 64'h10A, 0, 64'hF00D0000, 1,
                          0, 64'h108, 8'h00, 0, 64'hFFFFFFFFFFFFF00D));
        vecs.push_back(mk(0, 3'b101, 64'h10A, 0, 64'hF00D0000, 0,
                          0, 64'h108, 8'h00, 0, 64'hF00D));
        vecs.push_back(mk(0, 3'b110, 64'h204, 0, 64'h8765432100000000, 2,
                          0, 64'h200, 8'h00, 0, 64'h87654321));
        vecs.push_back(mk(0, 3'b010, 64'h204, 0, 64'h8765432100000000, 0,
                          0, 64'h200, 8'h00, 0, 64'hFFFFFFFF87654321));
        vecs.push_back(mk(1, 3'b010, 64'h304, 64'hFFFFFFFFDEADBEEF, 0, 1,
                          0, 64'h300, 8'hF0, 64'hDEADBEEF00000000, 0));
        vecs.push_back(mk(1, 3'b000, 64'h007, 64'h123456789ABCDE5A, 0, 0,
                          0, 64'h000, 8'h80, 64'h5A00000000000000, 0));
        vecs.push_back(mk(1, 3'b011, 64'h018, 64'h0123456789ABCDEF, 0, 3,
                          0, 64'h018, 8'hFF, 64'h0123456789ABCDEF, 0));
        vecs.push_back(mk(0, 3'b111, 64'h100, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 3'b100, 64'h100, 64'h55, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b000, 64'h100, 0, 64'h7F, 0,
                          0, 64'h100, 8'h00, 0, 64'h7F));
`ifdef LSU_MISALIGN_SPLIT_EN
        vecs.push_back(mk(0, 3'b010, 64'h102, 0, 64'h0000776655440000, 0,
                          0, 64'h100, 8'h00, 0, 64'h77665544));
`else
        vecs.push_back(mk(0, 3'b010, 64'h102, 0, 0, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mk(0, 3'b011, 64'h104, 0, 0, 0, 1, 0, 0, 0, 0));
`endif
        // Ack in the very cycle the counter would expire.
        vecs.push_back(mk(0, 3'b011, 64'h1F8, 0, 64'hCAFEF00D12345678, 254,
                          0, 64'h1F8, 8'h00, 0, 64'hCAFEF00D12345678));

        foreach (vecs[i]) begin
            vidx = i;
            run_txn(vecs[i]);
        end

        // Timeout with no ack at all.
        vidx = 100;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'b011;
        req_addr   = 64'h40;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (mem_req === 1'b1 && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("to.req_cycles", 64'(n), 255);
        chk("to.resp_valid", resp_valid, 1);
        chk("to.resp_err", resp_err, 1);
        chk("to.rdata", resp_rdata, 0);
        @(negedge clk);
        chk("to.ready_after", req_ready, 1);
        chk("to.resp_once", resp_valid, 0);
        @(posedge clk); #1;

        // req_valid while busy is neither taken nor queued.
        vidx = 101;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'b011;
        req_addr   = 64'h100;
        @(posedge clk); #1;
        req_write  = 1'b1;
        req_addr   = 64'h500;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("busy.mem_addr", mem_addr, 64'h100);
            chk("busy.mem_we", mem_we, 0);
            chk("busy.ready", req_ready, 0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 64'h55;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = JUNK;
        @(negedge clk);
        chk("busy.resp_valid", resp_valid, 1);
        chk("busy.rdata", resp_rdata, 64'h55);
        @(posedge clk); #1;
        @(negedge clk);
        chk("busy.no_queue", mem_req, 0);
        chk("busy.no_resp", resp_valid, 0);
        @(posedge clk); #1;

        // Ack while idle is ignored.
        vidx = 102;
        mem_ack = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_ack.resp", resp_valid, 0);
            chk("idle_ack.mem_req", mem_req, 0);
            @(posedge clk); #1;
        end
        mem_ack = 1'b0;

        // Asynchronous reset in the middle of ISSUE.
        vidx = 103;
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'b011;
        req_addr   = 64'h80;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rmid.pre_req", mem_req, 1);
        reset = 1'b0;
        #1;
        chk("rmid.mem_req", mem_req, 0);
        chk("rmid.mem_addr", mem_addr, 0);
        chk("rmid.ready", req_ready, 1);
        chk("rmid.resp", resp_valid, 0);
        @(posedge clk); #2;
        reset = 1'b1;
        @(negedge clk);
        chk("rmid.no_resp", resp_valid, 0);
        @(posedge clk); #1;
        vidx = 104;
        run_txn(vecs[0]);

`ifdef LSU_MISALIGN_SPLIT_EN
        // Doubleword-crossing word: load merges beats, store splits lanes.
        vidx = 200;
        for (int s = 0; s < 2; s++) begin
            req_valid  = 1'b1;
            req_write  = (s == 1);
            req_funct3 = 3'b010;
            req_addr   = 64'h106;
            req_wdata  = 64'h11223344;
            @(posedge clk); #1;
            req_valid = 1'b0;
            for (int b = 0; b < 2; b++) begin
                mem_ack   = 1'b1;
                mem_rdata = (b == 0) ? 64'hAABB000000000000
                                     : 64'h000000000000CCDD;
                @(negedge clk);
                chk("sp.mem_req", mem_req, 1);
                chk("sp.mem_addr", mem_addr, (b == 0) ? 64'h100 : 64'h108);
                chk("sp.wstrb", mem_wstrb,
                    (s == 0) ? 8'h00 : ((b == 0) ? 8'hC0 : 8'h03));
                chk("sp.wdata", mem_wdata,
                    (s == 0) ? 64'h0 : ((b == 0) ? 64'h3344000000000000
                                                 : 64'h1122));
                @(posedge clk); #1;
                mem_ack   = 1'b0;
                mem_rdata = JUNK;
            end
            @(negedge clk);
            chk("sp.resp_valid", resp_valid, 1);
            chk("sp.resp_err", resp_err, 0);
            chk("sp.rdata", resp_rdata,
                (s == 0) ? 64'hFFFFFFFFCCDDAABB : 64'h0);
            @(posedge clk); #1;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
